// File: rtl/i2c_link_if.sv
// Request/observation bundle for the i2c_link endpoint pair.
// The master modport is the requester side, and the slave modport is the link side.
interface i2c_link_if;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    logic              enable;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              scl;
    logic              sda;
    logic              busy;
    logic              done;
    logic              ack_err;

    modport master (
        output enable, address, data_in,
        input  data_out, scl, sda, busy, done, ack_err
    );

    modport slave (
        input  enable, address, data_in,
        output data_out, scl, sda, busy, done, ack_err
    );
endinterface

// File: rtl/i2c_link.sv
// I2C write-only master engine and 7-bit-address slave engine.
// Both engines share an internal wired-AND SDA line, and the master alone drives SCL.
module i2c_link #(
    parameter logic [6:0] SLAVE_ADDR = 7'b0101101
) (
    input  logic        clk,
    input  logic        reset,
    i2c_link_if.slave   bus
);
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [3:0] {
        M_IDLE, M_START, M_ADDR, M_RW, M_ACK1, M_DATA, M_ACK2, M_STOP, M_DONE
    } m_state_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_WAIT
    } s_state_t;

    // Master registers
    m_state_t          m_state, m_state_d;
    logic              m_ph, m_ph_d;
    logic [CNT_W-1:0]  m_cnt, m_cnt_d;
    logic [ADDR_W-1:0] m_addr, m_addr_d;
    logic [DATA_W-1:0] m_data, m_data_d;
    logic              m_pull, m_pull_d;
    logic              scl_q, scl_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ack_err_q, ack_err_d;

    // Slave registers
    s_state_t          s_state, s_state_d;
    logic [CNT_W-1:0]  s_cnt, s_cnt_d;
    logic [DATA_W-1:0] s_shift, s_shift_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              s_pull, s_pull_d;
    logic              prev_scl, prev_sda;

    logic sda_bus;
    logic start_det;
    logic stop_det;
    logic bit_sample;

    assign sda_bus = ~(m_pull | s_pull);

    // Master state register
    always_ff @(posedge clk) begin
        if (reset) begin
            m_state   <= M_IDLE;
            m_ph      <= 1'b0;
            m_cnt     <= '0;
            m_addr    <= '0;
            m_data    <= '0;
            m_pull    <= 1'b0;
            scl_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            m_state   <= m_state_d;
            m_ph      <= m_ph_d;
            m_cnt     <= m_cnt_d;
            m_addr    <= m_addr_d;
            m_data    <= m_data_d;
            m_pull    <= m_pull_d;
            scl_q     <= scl_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
        end
    end

    // Master next state.
    // Each bit slot takes two cycles: m_ph=0 is the low phase and m_ph=1 is the high phase.
    always_comb begin
        m_state_d = m_state;
        m_ph_d    = m_ph;
        m_cnt_d   = m_cnt;
        m_addr_d  = m_addr;
        m_data_d  = m_data;
        ack_err_d = ack_err_q;

        unique case (m_state)
            M_IDLE: begin
                if (bus.enable) begin
                    m_addr_d  = bus.address;
                    m_data_d  = bus.data_in;
                    ack_err_d = 1'b0;
                    m_state_d = M_START;
                end
            end
            M_START: begin
                m_ph_d    = 1'b0;
                m_cnt_d   = CNT_W'(ADDR_W - 1);
                m_state_d = M_ADDR;
            end
            M_ADDR: begin
                m_ph_d = ~m_ph;
                if (m_ph) begin
                    if (m_cnt == '0) m_state_d = M_RW;
                    else             m_cnt_d   = m_cnt - CNT_W'(1);
                end
            end
            M_RW: begin
                m_ph_d = ~m_ph;
                if (m_ph) m_state_d = M_ACK1;
            end
            M_ACK1: begin
                m_ph_d = ~m_ph;
                if (m_ph) begin
                    if (sda_bus) begin
                        ack_err_d = 1'b1;
                        m_state_d = M_STOP;
                    end else begin
                        m_cnt_d   = CNT_W'(DATA_W - 1);
                        m_state_d = M_DATA;
                    end
                end
            end
            M_DATA: begin
                m_ph_d = ~m_ph;
                if (m_ph) begin
                    if (m_cnt == '0) m_state_d = M_ACK2;
                    else             m_cnt_d   = m_cnt - CNT_W'(1);
                end
            end
            M_ACK2: begin
                m_ph_d = ~m_ph;
                if (m_ph) begin
                    if (sda_bus) ack_err_d = 1'b1;
                    m_state_d = M_STOP;
                end
            end
            M_STOP: begin
                m_ph_d = ~m_ph;
                if (m_ph) m_state_d = M_DONE;
            end
            M_DONE: begin
                if (!bus.enable) m_state_d = M_IDLE;
            end
            default: m_state_d = M_IDLE;
        endcase
    end

    // Bus drive for the coming cycle, decoded from the next state
    always_comb begin
        scl_d    = 1'b1;
        m_pull_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        unique case (m_state_d)
            M_START: begin
                m_pull_d = 1'b1;
                busy_d   = 1'b1;
            end
            M_ADDR: begin
                scl_d    = m_ph_d;
                m_pull_d = ~m_addr_d[m_cnt_d];
                busy_d   = 1'b1;
            end
            M_RW: begin
                scl_d    = m_ph_d;
                m_pull_d = 1'b1;
                busy_d   = 1'b1;
            end
            M_ACK1, M_ACK2: begin
                scl_d  = m_ph_d;
                busy_d = 1'b1;
            end
            M_DATA: begin
                scl_d    = m_ph_d;
                m_pull_d = ~m_data_d[m_cnt_d];
                busy_d   = 1'b1;
            end
            M_STOP: begin
                scl_d    = m_ph_d;
                m_pull_d = 1'b1;
                busy_d   = 1'b1;
            end
            M_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // Slave state register and bus history
    always_ff @(posedge clk) begin
        if (reset) begin
            s_state    <= S_IDLE;
            s_cnt      <= '0;
            s_shift    <= '0;
            data_out_q <= '0;
            s_pull     <= 1'b0;
            prev_scl   <= 1'b1;
            prev_sda   <= 1'b1;
        end else begin
            s_state    <= s_state_d;
            s_cnt      <= s_cnt_d;
            s_shift    <= s_shift_d;
            data_out_q <= data_out_d;
            s_pull     <= s_pull_d;
            prev_scl   <= scl_q;
            prev_sda   <= sda_bus;
        end
    end

    assign start_det  = prev_sda & ~sda_bus & scl_q;
    assign stop_det   = ~prev_sda & sda_bus & scl_q;
    // prev_scl still holds the low-phase level at the posedge that ends a high phase
    assign bit_sample = scl_q & ~prev_scl;

    // Slave next state
    always_comb begin
        s_state_d  = s_state;
        s_cnt_d    = s_cnt;
        s_shift_d  = s_shift;
        data_out_d = data_out_q;
        s_pull_d   = s_pull;

        if (start_det) begin
            s_state_d = S_ADDR;
            s_cnt_d   = '0;
            s_pull_d  = 1'b0;
        end else if (stop_det) begin
            s_state_d = S_IDLE;
            s_pull_d  = 1'b0;
        end else if (bit_sample) begin
            unique case (s_state)
                S_ADDR: begin
                    s_shift_d = {s_shift[DATA_W-2:0], sda_bus};
                    s_cnt_d   = s_cnt + CNT_W'(1);
                    if (s_cnt == CNT_W'(DATA_W - 1)) begin
                        s_cnt_d = '0;
                        if (s_shift[ADDR_W-1:0] == SLAVE_ADDR && !sda_bus) begin
                            s_pull_d  = 1'b1;
                            s_state_d = S_ACK1;
                        end else begin
                            s_state_d = S_WAIT;
                        end
                    end
                end
                S_ACK1: begin
                    s_pull_d  = 1'b0;
                    s_cnt_d   = '0;
                    s_state_d = S_DATA;
                end
                S_DATA: begin
                    s_shift_d = {s_shift[DATA_W-2:0], sda_bus};
                    s_cnt_d   = s_cnt + CNT_W'(1);
                    if (s_cnt == CNT_W'(DATA_W - 1)) begin
                        data_out_d = {s_shift[DATA_W-2:0], sda_bus};
                        s_cnt_d    = '0;
                        s_pull_d   = 1'b1;
                        s_state_d  = S_ACK2;
                    end
                end
                S_ACK2: begin
                    s_pull_d  = 1'b0;
                    s_state_d = S_WAIT;
                end
                default: ;
            endcase
        end
    end

    assign bus.scl      = scl_q;
    assign bus.sda      = sda_bus;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ack_err  = ack_err_q;
    assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_i2c_link.sv
// Scoreboard bench for i2c_link: checks full write and NACK transactions, bus bit order,
// START/STOP edges, enable handshake and mid-transfer reset.
module tb_i2c_link;
    localparam logic [6:0] SLAVE_ADDR = 7'h2D;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [7:0] model_data = 8'h00;

    i2c_link_if bus ();

    i2c_link #(.SLAVE_ADDR(SLAVE_ADDR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.address = '0;
        bus.data_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.scl !== 1'b1)      begin failures++; $display("FAIL reset_scl got=%b exp=1", bus.scl); end
        checks++; if (bus.sda !== 1'b1)      begin failures++; $display("FAIL reset_sda got=%b exp=1", bus.sda); end
        checks++; if (bus.data_out !== 8'h0) begin failures++; $display("FAIL reset_data_out got=%h exp=00", bus.data_out); end
        checks++; if (bus.busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.ack_err !== 1'b0)  begin failures++; $display("FAIL reset_ack_err got=%b exp=0", bus.ack_err); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One full transaction, monitored cycle by cycle, then optional enable hold and release
    task automatic run_txn(input logic [6:0] addr, input logic [7:0] data, input int hold_cycles);
        logic match;
        exp_t e;
        exp_t got;
        logic pscl, psda;
        int   start_k, done_k, bad_edges, exp_len;
        logic start_seen, stop_seen;
        logic bits[$];
        logic exp_bits[$];
        int   bit_errs;

        match      = (addr == SLAVE_ADDR);
        exp_len    = match ? 39 : 21;
        if (match) model_data = data;
        e.data     = model_data;
        e.err      = ~match;
        sb.push_back(e);

        for (int i = 6; i >= 0; i--) exp_bits.push_back(addr[i]);
        exp_bits.push_back(1'b0);
        exp_bits.push_back(~match);
        if (match) begin
            for (int i = 7; i >= 0; i--) exp_bits.push_back(data[i]);
            exp_bits.push_back(1'b0);
        end
        exp_bits.push_back(1'b0);

        start_k = -1; done_k = -1; bad_edges = 0;
        start_seen = 1'b0; stop_seen = 1'b0;
        pscl = bus.scl; psda = bus.sda;
        bus.address = addr;
        bus.data_in = data;
        bus.enable  = 1'b1;

        for (int k = 1; k <= 80 && done_k < 0; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1 && start_k < 0) start_k = k;
            if (bus.scl === 1'b1 && pscl === 1'b1 && bus.sda !== psda) begin
                if (bus.sda === 1'b0 && k == start_k)      start_seen = 1'b1;
                else if (bus.sda === 1'b1 && bus.done === 1'b1) stop_seen = 1'b1;
                else bad_edges++;
            end
            if (bus.scl === 1'b1 && pscl === 1'b0) bits.push_back(bus.sda);
            if (match && start_k > 0 && k == start_k + 35) begin
                checks++;
                if (bus.data_out !== data) begin
                    failures++; $display("FAIL data_before_ack2 got=%h exp=%h", bus.data_out, data);
                end
            end
            if (bus.done === 1'b1) done_k = k;
            pscl = bus.scl; psda = bus.sda;
        end

        checks++;
        if (done_k < 0 || start_k < 0) begin
            failures++; $display("FAIL txn_timeout start=%0d done=%0d", start_k, done_k);
        end else if (done_k - start_k != exp_len) begin
            failures++; $display("FAIL txn_length got=%0d exp=%0d", done_k - start_k, exp_len);
        end
        checks++; if (!start_seen)    begin failures++; $display("FAIL start_edge got=0 exp=1"); end
        checks++; if (!stop_seen)     begin failures++; $display("FAIL stop_edge got=0 exp=1"); end
        checks++; if (bad_edges != 0) begin failures++; $display("FAIL sda_while_scl_high got=%0d exp=0", bad_edges); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_at_done got=%b exp=0", bus.busy); end

        bit_errs = 0;
        if (bits.size() != exp_bits.size()) bit_errs = 100;
        else for (int i = 0; i < bits.size(); i++) if (bits[i] !== exp_bits[i]) bit_errs++;
        checks++;
        if (bit_errs != 0) begin
            failures++; $display("FAIL bus_bits got_len=%0d exp_len=%0d bad=%0d", bits.size(), exp_bits.size(), bit_errs);
        end

        e = sb.pop_front();
        got.data = bus.data_out;
        got.err  = bus.ack_err;
        checks++;
        if (got !== e) begin
            failures++; $display("FAIL result data=%h err=%b exp data=%h err=%b", got.data, got.err, e.data, e.err);
        end

        if (hold_cycles > 0) begin
            int busy_seen = 0;
            repeat (hold_cycles) begin
                @(negedge clk);
                if (bus.busy !== 1'b0 || bus.done !== 1'b1) busy_seen++;
            end
            checks++;
            if (busy_seen != 0) begin failures++; $display("FAIL enable_hold_restart got=%0d exp=0", busy_seen); end
        end

        bus.enable = 1'b0;
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL done_release got=%b exp=0", bus.done); end
    endtask

    task automatic test_write();
        run_txn(7'h2D, 8'h67, 0);
    endtask

    task automatic test_byte_patterns();
        run_txn(7'h2D, 8'hB5, 0);
        run_txn(7'h2D, 8'h00, 0);
        run_txn(7'h2D, 8'hFF, 0);
    endtask

    task automatic test_nack();
        run_txn(7'h2C, 8'h3C, 0);
    endtask

    task automatic test_hold();
        run_txn(7'h2D, 8'h5A, 12);
    endtask

    task automatic test_reset_mid();
        int k;
        bus.address = 7'h2D;
        bus.data_in = 8'hC3;
        bus.enable  = 1'b1;
        k = 0;
        while (bus.busy !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_start got=%b exp=1", bus.busy); end
        repeat (25) @(negedge clk);
        reset = 1'b1;
        bus.enable = 1'b0;
        model_data = 8'h00;
        @(negedge clk);
        checks++; if (bus.scl !== 1'b1)          begin failures++; $display("FAIL mid_reset_scl got=%b exp=1", bus.scl); end
        checks++; if (bus.sda !== 1'b1)          begin failures++; $display("FAIL mid_reset_sda got=%b exp=1", bus.sda); end
        checks++; if (bus.data_out !== model_data) begin failures++; $display("FAIL mid_reset_data_out got=%h exp=%h", bus.data_out, model_data); end
        checks++; if (bus.busy !== 1'b0)         begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", bus.busy); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_txn(7'h2D, 8'hA5, 0);
        run_txn(7'h2D, 8'h3C, 0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_byte_patterns();
        test_nack();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
